// File: rtl/chase_counter_arbiter.sv
// Leader/follower counter pair sharing one incrementer; arbitrates the two
// advance requests round-robin and keeps the follower at or behind the leader.
module chase_counter_arbiter #(
   parameter int            W       = 8,
   parameter logic [W-1:0]  CNT_MAX = {W{1'b1}}
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_lead_req,
   input  logic         i_fol_req,
   input  logic         i_clr,
   output logic         o_lead_gnt,
   output logic         o_fol_gnt,
   output logic [W-1:0] o_lead_cnt,
   output logic [W-1:0] o_fol_cnt,
   output logic [W-1:0] o_gap,
   output logic [1:0]   o_state,
   output logic         o_wrap,
   output logic         o_inv_ok
);

   typedef enum logic [1:0] {
      EQUAL = 2'd0,
      AHEAD = 2'd1,
      SAT   = 2'd2,
      FLUSH = 2'd3
   } state_t;

   localparam logic [W-1:0] ONE  = W'(1);
   localparam logic [W-1:0] ZERO = W'(0);

   state_t       r_state;
   state_t       w_state_nxt;
   logic [W-1:0] r_lead;
   logic [W-1:0] r_fol;
   logic [W-1:0] w_lead_nxt;
   logic [W-1:0] w_fol_nxt;
   logic         r_wrap;
   logic         w_wrap_nxt;
   logic         r_ptr_fol;
   logic         w_ptr_nxt;
   logic         w_wrap_cond;
   logic         w_lead_try;
   logic         w_fol_try;
   logic         w_block;
   logic         w_lead_gnt;
   logic         w_fol_gnt;

   // A saturated leader may only move again by wrapping the whole pair.
   assign w_wrap_cond = (r_lead == CNT_MAX) && (r_fol == CNT_MAX);
   assign w_lead_try  = i_lead_req && ((r_lead != CNT_MAX) || w_wrap_cond);
   assign w_fol_try   = i_fol_req && (r_fol < r_lead);
   assign w_block     = i_clr || (r_state == FLUSH) || !i_rst_n;

   always_comb begin
      w_lead_gnt = 1'b0;
      w_fol_gnt  = 1'b0;
      if (w_block) begin
         w_lead_gnt = 1'b0;
         w_fol_gnt  = 1'b0;
      end else if (w_lead_try && w_fol_try) begin
         w_lead_gnt = !r_ptr_fol;
         w_fol_gnt  = r_ptr_fol;
      end else begin
         w_lead_gnt = w_lead_try;
         w_fol_gnt  = w_fol_try;
      end
   end

   always_comb begin
      w_lead_nxt  = r_lead;
      w_fol_nxt   = r_fol;
      w_wrap_nxt  = 1'b0;
      w_ptr_nxt   = r_ptr_fol;
      w_state_nxt = r_state;
      if (i_clr) begin
         w_lead_nxt = ZERO;
         w_fol_nxt  = ZERO;
         w_ptr_nxt  = 1'b0;
      end else if (w_lead_gnt) begin
         w_ptr_nxt = 1'b1;
         if (w_wrap_cond) begin
            w_lead_nxt = ZERO;
            w_fol_nxt  = ZERO;
            w_wrap_nxt = 1'b1;
         end else begin
            w_lead_nxt = r_lead + ONE;
         end
      end else if (w_fol_gnt) begin
         w_fol_nxt = r_fol + ONE;
         w_ptr_nxt = 1'b0;
      end else begin
         w_ptr_nxt = r_ptr_fol;
      end

      // State is classified from the post-update counter values.
      if (i_clr) begin
         w_state_nxt = FLUSH;
      end else if (w_lead_nxt == CNT_MAX) begin
         w_state_nxt = SAT;
      end else if (w_lead_nxt == w_fol_nxt) begin
         w_state_nxt = EQUAL;
      end else begin
         w_state_nxt = AHEAD;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lead    <= ZERO;
         r_fol     <= ZERO;
         r_wrap    <= 1'b0;
         r_ptr_fol <= 1'b0;
         r_state   <= EQUAL;
      end else begin
         r_lead    <= w_lead_nxt;
         r_fol     <= w_fol_nxt;
         r_wrap    <= w_wrap_nxt;
         r_ptr_fol <= w_ptr_nxt;
         r_state   <= w_state_nxt;
      end
   end

   assign o_lead_gnt = w_lead_gnt;
   assign o_fol_gnt  = w_fol_gnt;
   assign o_lead_cnt = r_lead;
   assign o_fol_cnt  = r_fol;
   assign o_gap      = r_lead - r_fol;
   assign o_state    = r_state;
   assign o_wrap     = r_wrap;
   assign o_inv_ok   = (r_fol <= r_lead);

endmodule

// File: doc/chase_counter_arbiter.md
# chase_counter_arbiter

Arbiter and sequencer for a shared leader/follower counter pair, a two-register `W`-bit datapath.
- Owns the single shared incrementer and grants it to one of two requesters per cycle: leader advance or follower advance.
- Invariant: the follower never exceeds the leader (`fol_cnt <= lead_cnt`).
- Handles saturation at `CNT_MAX`, wrap-around of the pair, and synchronous clear.
- Sits between the requesting agents and the counter datapath, and exports a combinational invariant flag for formal checking.

## Interface
- `W`, default 8: counter width in bits.
- `CNT_MAX`, default {W{1'b1}}: leader saturation value, must be < 2^W.
- `clk`  in  1  : single clock, rising edge.
- `rst_n`  in  1  : asynchronous reset, active-low.
- `lead_req`  in  1  : request to advance the leader counter.
- `fol_req`  in  1  : request to advance the follower counter.
- `clr`  in  1  : synchronous clear request; highest priority.
- `lead_gnt`  out  1  : leader request granted this cycle (combinational).
- `fol_gnt`  out  1  : follower request granted this cycle (combinational).
- `lead_cnt`  out  W  : leader count (registered).
- `fol_cnt`  out  W  : follower count (registered).
- `gap`  out  W  : lead_cnt - fol_cnt, modulo 2^W; never wraps negative.
- `state`  out  2  : EQUAL=0, AHEAD=1, SAT=2, FLUSH=3.
- `wrap`  out  1  : one-cycle registered pulse after a pair wrap.
- `inv_ok`  out  1  : combinational (fol_cnt <= lead_cnt); must always be 1.

## Operation
- **Reset** (rst_n=0, asynchronous):
  - lead_cnt=0, fol_cnt=0, state=EQUAL, wrap=0.
  - Round-robin pointer favours the leader.
  - lead_gnt=fol_gnt=0 while rst_n=0.
- **Eligibility**:
  - Leader eligible iff lead_cnt != CNT_MAX, or the wrap condition holds (lead_cnt==fol_cnt==CNT_MAX).
  - Follower eligible iff fol_cnt < lead_cnt.
- **Grant**: at most one grant per cycle, because the incrementer is shared.
  - No grants while clr=1 or state=FLUSH.
  - Only one requester is both requesting and eligible: that one is granted.
  - Both are requesting and eligible: the round-robin pointer decides. After any grant the pointer moves to the other requester.
  - Ineligible requests are held off, never dropped silently. Requesters keep req high until they see gnt.
- **Update** at the clock edge after a grant:
  - lead_gnt: lead_cnt += 1.
  - fol_gnt: fol_cnt += 1.
  - Wrap grant (lead_gnt under the wrap condition): both counters load 0, wrap=1 for one cycle.
- **Clear**: clr=1 zeroes both counters at the next edge and enters FLUSH. The pointer resets to favour the leader.
- **Next-state**, from next-cycle counter values:
  - clr → FLUSH.
  - else if next lead==CNT_MAX → SAT.
  - else if next lead==next fol → EQUAL.
  - else → AHEAD.
  - FLUSH lasts one cycle, then EQUAL, unless clr is still high.
- **Arithmetic**:
  - All increments are W-bit.
  - lead_cnt never exceeds CNT_MAX.
  - fol_cnt never exceeds lead_cnt.
  - gap is exact, with no underflow.

## Timing
- Grant latency: 0 cycles (gnt in the same cycle as an eligible req). Counter latency: 1 cycle.
- state, wrap, and the counters are registered. gap and inv_ok are combinational from the registers.
- clr asserted mid-operation: grants drop in the same cycle. Counters read 0 and state FLUSH after 1 edge, then EQUAL after 2 edges.
- rst_n deasserts synchronously to clk externally. The first grant is possible in the first cycle with rst_n=1.
- Simultaneous lead_req and fol_req in SAT with fol_cnt < CNT_MAX: only the follower is eligible, so fol_gnt=1.

## Test plan
- Reset, then lead_req=1 for 3 cycles → lead_gnt=1 each cycle; lead_cnt=3, fol_cnt=0, state=AHEAD, gap=3.
- From 0/0, fol_req=1 alone for 2 cycles → fol_gnt=0, counters stay 0/0, state=EQUAL, inv_ok=1.
- W=3, from 0/0, both req high for 4 cycles → grants in order lead, fol, lead, fol; ends 2/2, state=EQUAL.
- W=3, CNT_MAX=7, saturation and wrap:
  - lead_req 7 cycles → lead_cnt=7, state=SAT.
  - One more lead_req → lead_gnt=0.
  - fol_req 7 cycles → fol_cnt=7.
  - lead_req once → both 0, wrap=1 for one cycle, state=EQUAL.
- At lead=5, fol=2 with both req high, pulse clr for 1 cycle → gnts=0 that cycle; next cycle 0/0 and FLUSH; then EQUAL, with grants resuming leader-first.
- Drop rst_n asynchronously mid-cycle at lead=4, fol=1 → outputs go to 0/0, EQUAL, gnts=0 without waiting for a clock edge.
